// File: rtl/nvram_pkg.sv
// Shared definitions for the EAROM NVRAM mirror.
//   nv_state_t    : autosave/transfer FSM states
//   NV_DEPTH/NV_AW: default mirror size (bytes / address bits)
//   NV_INDEX_DEF  : default hps_io ioctl_index for NVRAM transfers
package nvram_pkg;
   localparam int          NV_DEPTH     = 64;
   localparam int          NV_AW        = 6;
   localparam logic [7:0]  NV_INDEX_DEF = 8'd4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT   = 3'd1,
      REQ    = 3'd2,
      UPLOAD = 3'd3,
      DNLOAD = 3'd4
   } nv_state_t;
endpackage

// File: rtl/dpram_nv.sv
// True dual-port DEPTHx8 RAM with registered read on both ports.
//   clk_i/rst_i      : clock, async active-high reset (read registers only)
//   a_*              : CPU port, write-first on its own write
//   b_*              : HPS port, write beats port A on an address collision
// Array contents are never reset.
module dpram_nv import nvram_pkg::*; #(
   parameter int DEPTH = NV_DEPTH,
   parameter int AW    = NV_AW
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [AW-1:0] a_addr_i,
   input  logic [7:0]    a_din_i,
   input  logic          a_we_i,
   output logic [7:0]    a_dout_o,
   input  logic [AW-1:0] b_addr_i,
   input  logic [7:0]    b_din_i,
   input  logic          b_we_i,
   output logic [7:0]    b_dout_o
);
   logic [7:0] mem_q [DEPTH];
   logic       collide;

   assign collide = b_we_i && (a_addr_i == b_addr_i);

   always_ff @(posedge clk_i) begin
      if (a_we_i && !collide) mem_q[a_addr_i] <= a_din_i;
      if (b_we_i)             mem_q[b_addr_i] <= b_din_i;
   end

   // Port A shows whatever value actually lands in the array this cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_dout_o <= 8'h00;
         b_dout_o <= 8'h00;
      end else begin
         if (collide)     a_dout_o <= b_din_i;
         else if (a_we_i) a_dout_o <= a_din_i;
         else             a_dout_o <= mem_q[a_addr_i];
         b_dout_o <= mem_q[b_addr_i];
      end
   end
endmodule

// File: rtl/earom_nvram_upload.sv
// EAROM byte mirror between hps_io and a vector-game core.
//   clk_i, reset           : system clock, async power-on reset (active high)
//   cpu_addr/din/we/dout   : game EAROM port, synchronous read
//   ioctl_*                : hps_io upload/download interface
//   ioctl_upload_req       : autosave request (gated by autosave_en)
//   nv_valid               : a restore download has completed
//   state_o, dirty_o       : FSM state and dirty flag for observation
// Upload read pipeline: rd sampled at edge N, RAM read at N+1, ioctl_din at N+2.
module earom_nvram_upload import nvram_pkg::*; #(
   parameter int          DEPTH      = NV_DEPTH,
   parameter int          AW         = NV_AW,
   parameter logic [7:0]  NV_INDEX   = NV_INDEX_DEF,
   parameter int unsigned SAVE_DELAY = 25000000
) (
   input  logic          clk_i,
   input  logic          reset,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_din,
   input  logic          cpu_we,
   output logic [7:0]    cpu_dout,
   input  logic          ioctl_download,
   input  logic          ioctl_upload,
   input  logic [7:0]    ioctl_index,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   input  logic          ioctl_wr,
   input  logic          ioctl_rd,
   output logic [7:0]    ioctl_din,
   output logic          ioctl_upload_req,
   input  logic          autosave_en,
   output logic          nv_valid,
   output nv_state_t     state_o,
   output logic          dirty_o
);
   localparam logic [31:0] RELOAD  = 32'(SAVE_DELAY - 1);
   localparam logic [24:0] DEPTH_A = 25'(DEPTH);

   nv_state_t     state_q;
   logic [31:0]   cnt_q;
   logic          dirty_q, req_q, nv_valid_q, we_seen_q;
   logic          upl_sel_q, upl_q, dnl_sel_q, dnl_q;
   logic [AW-1:0] rd_addr_q;
   logic          rd_p1_q, rd_oor1_q, rd_p2_q, rd_oor2_q;
   logic [7:0]    din_q, b_dout;

   logic sel, upl_act, dnl_act, rd_fire, dl_wr;
   logic upl_rise, upl_fall, dnl_rise, dnl_fall;
   logic [AW-1:0] b_addr;

   assign sel      = (ioctl_index == NV_INDEX);
   assign upl_act  = ioctl_upload & sel;
   assign dnl_act  = ioctl_download & sel;
   assign rd_fire  = upl_act & ioctl_rd;
   assign dl_wr    = dnl_act & ioctl_wr & (ioctl_addr < DEPTH_A);
   assign upl_rise = upl_act & ~upl_sel_q;
   assign dnl_rise = dnl_act & ~dnl_sel_q;
   // Transfer ends are taken from the raw strobes so an index change cannot hide them.
   assign upl_fall = ~ioctl_upload & upl_q;
   assign dnl_fall = ~ioctl_download & dnl_q;
   // Port B is shared: a download write takes it, otherwise it serves the read pipeline.
   assign b_addr   = dl_wr ? ioctl_addr[AW-1:0] : rd_addr_q;

   dpram_nv #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk_i    (clk_i),
      .rst_i    (reset),
      .a_addr_i (cpu_addr),
      .a_din_i  (cpu_din),
      .a_we_i   (cpu_we),
      .a_dout_o (cpu_dout),
      .b_addr_i (b_addr),
      .b_din_i  (ioctl_dout),
      .b_we_i   (dl_wr),
      .b_dout_o (b_dout)
   );

   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         rd_addr_q <= '0;
         rd_p1_q   <= 1'b0;
         rd_oor1_q <= 1'b0;
         rd_p2_q   <= 1'b0;
         rd_oor2_q <= 1'b0;
         din_q     <= 8'h00;
      end else begin
         rd_p1_q <= rd_fire;
         if (rd_fire) begin
            rd_addr_q <= ioctl_addr[AW-1:0];
            rd_oor1_q <= (ioctl_addr >= DEPTH_A);
         end
         rd_p2_q   <= rd_p1_q;
         rd_oor2_q <= rd_oor1_q;
         if (rd_p2_q) din_q <= rd_oor2_q ? 8'hFF : b_dout;
      end
   end

   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dirty_q    <= 1'b0;
         req_q      <= 1'b0;
         nv_valid_q <= 1'b0;
         we_seen_q  <= 1'b0;
         upl_sel_q  <= 1'b0;
         upl_q      <= 1'b0;
         dnl_sel_q  <= 1'b0;
         dnl_q      <= 1'b0;
      end else begin
         upl_sel_q <= upl_act;
         upl_q     <= ioctl_upload;
         dnl_sel_q <= dnl_act;
         dnl_q     <= ioctl_download;
         req_q     <= 1'b0;
         if (cpu_we)                           cnt_q <= RELOAD;
         else if (state_q == WAIT && cnt_q != 0) cnt_q <= cnt_q - 32'd1;
         if (state_q != UPLOAD) we_seen_q <= 1'b0;

         if (dnl_rise) begin
            state_q <= DNLOAD;
         end else begin
            case (state_q)
               IDLE: begin
                  if (upl_rise)               state_q <= UPLOAD;
                  else if (cpu_we || dirty_q) state_q <= WAIT;
               end
               WAIT: begin
                  if (upl_rise) state_q <= UPLOAD;
                  else if (!cpu_we && cnt_q == 0) begin
                     state_q <= REQ;
                     req_q   <= autosave_en;
                  end
               end
               REQ: begin
                  // New game writes postpone the save until the game goes quiet again.
                  if (upl_rise)    state_q <= UPLOAD;
                  else if (cpu_we) state_q <= WAIT;
                  else             req_q   <= autosave_en;
               end
               UPLOAD: begin
                  if (cpu_we) we_seen_q <= 1'b1;
                  if (upl_fall) begin
                     if (we_seen_q || cpu_we) begin
                        state_q <= WAIT;
                        cnt_q   <= RELOAD;
                     end else begin
                        state_q <= IDLE;
                        dirty_q <= 1'b0;
                     end
                  end
               end
               DNLOAD: begin
                  if (dnl_fall) begin
                     state_q    <= IDLE;
                     nv_valid_q <= 1'b1;
                     dirty_q    <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
         // A write in the same cycle as a clear keeps the mirror dirty.
         if (cpu_we) dirty_q <= 1'b1;
      end
   end

   assign ioctl_din        = din_q;
   assign ioctl_upload_req = req_q;
   assign nv_valid         = nv_valid_q;
   assign state_o          = state_q;
   assign dirty_o          = dirty_q;
endmodule

// File: tb/tb_earom_nvram_upload.sv
// Bench for earom_nvram_upload with a short save delay.
module tb_earom_nvram_upload;
   import nvram_pkg::*;
   localparam int SD = 16;

   logic        clk_i = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  cpu_addr = '0;
   logic [7:0]  cpu_din = '0;
   logic        cpu_we = 1'b0;
   logic [7:0]  cpu_dout;
   logic        ioctl_download = 1'b0, ioctl_upload = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        ioctl_wr = 1'b0, ioctl_rd = 1'b0;
   logic [7:0]  ioctl_din;
   logic        ioctl_upload_req;
   logic        autosave_en = 1'b1;
   logic        nv_valid;
   nv_state_t   state_o;
   logic        dirty_o;

   earom_nvram_upload #(.DEPTH(64), .AW(6), .NV_INDEX(8'd4), .SAVE_DELAY(SD)) dut (
      .clk_i(clk_i), .reset(reset), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
      .cpu_dout(cpu_dout), .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
      .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din),
      .ioctl_upload_req(ioctl_upload_req), .autosave_en(autosave_en), .nv_valid(nv_valid),
      .state_o(state_o), .dirty_o(dirty_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0, n_err = 0;
   logic [7:0] model [64];

   typedef struct {
      logic       we;
      logic [5:0] addr;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;
   vec_t vec [8];

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic cpu_op(input logic we, input logic [5:0] a, input logic [7:0] d);
      cpu_we = we; cpu_addr = a; cpu_din = d;
      step();
      cpu_we = 1'b0;
      if (we) model[a] = d;
   endtask

   task automatic hps_rd(input logic [24:0] a, input logic [7:0] exp, input string nm);
      logic [7:0] prev;
      ioctl_addr = a; ioctl_rd = 1'b1;
      step();
      ioctl_rd = 1'b0;
      prev = ioctl_din;
      step();
      check({nm, "_early"}, ioctl_din, prev);
      step();
      check(nm, ioctl_din, exp);
   endtask

   task automatic wait_req(output int n);
      n = 0;
      while (!ioctl_upload_req && n < 200) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n, first;
      logic [5:0] a;
      logic [7:0] d;
      logic w;

      vec[0] = '{1'b1, 6'd3,  8'h5A, 8'h5A};
      vec[1] = '{1'b1, 6'd3,  8'hC3, 8'hC3};
      vec[2] = '{1'b0, 6'd3,  8'h00, 8'hC3};
      vec[3] = '{1'b1, 6'd0,  8'h11, 8'h11};
      vec[4] = '{1'b0, 6'd0,  8'hEE, 8'h11};
      vec[5] = '{1'b0, 6'd3,  8'h00, 8'hC3};
      vec[6] = '{1'b1, 6'd63, 8'h22, 8'h22};
      vec[7] = '{1'b0, 6'd63, 8'h00, 8'h22};

      // reset state
      step(); step();
      check("rst_cpu_dout", cpu_dout, 8'h00);
      check("rst_din", ioctl_din, 8'h00);
      check("rst_req", ioctl_upload_req, 1'b0);
      check("rst_nv_valid", nv_valid, 1'b0);
      check("rst_dirty", dirty_o, 1'b0);
      check("rst_state", state_o, IDLE);
      reset = 1'b0;
      step();

      // fill, then random CPU traffic against the byte model
      for (int i = 0; i < 64; i++) begin
         d = 8'($urandom);
         cpu_op(1'b1, 6'(i), d);
         check("fill", cpu_dout, d);
      end
      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom_range(0, 1));
         a = 6'($urandom_range(0, 63));
         d = 8'($urandom);
         cpu_op(w, a, d);
         check("rand_cpu", cpu_dout, model[a]);
      end

      // table vectors
      for (int i = 0; i < 8; i++) begin
         cpu_op(vec[i].we, vec[i].addr, vec[i].din);
         check($sformatf("vec%0d", i), cpu_dout, vec[i].exp);
      end
      check("dirty_after_wr", dirty_o, 1'b1);

      // save delay: one write, then idle
      cpu_op(1'b1, 6'd7, 8'h77);
      wait_req(n);
      check("delay_cycles", n, SD);

      // a second write at cycle 10 restarts the count
      cpu_op(1'b1, 6'd8, 8'h88);
      first = 0;
      for (int i = 1; i <= 30; i++) begin
         if (i == 10) cpu_op(1'b1, 6'd9, 8'h99);
         else step();
         if (ioctl_upload_req && first == 0) first = i;
      end
      check("restart_cycles", first, 10 + SD);

      // autosave disabled
      autosave_en = 1'b0;
      cpu_op(1'b1, 6'd9, 8'h9A);
      for (int i = 0; i < 20; i++) step();
      check("noauto_req", ioctl_upload_req, 1'b0);
      check("noauto_state", state_o, REQ);
      autosave_en = 1'b1;
      step();
      check("auto_req", ioctl_upload_req, 1'b1);

      // upload serving
      ioctl_index = 8'd4; ioctl_upload = 1'b1;
      step();
      check("upl_state", state_o, UPLOAD);
      check("upl_req_low", ioctl_upload_req, 1'b0);
      hps_rd(25'd64, 8'hFF, "rd64");
      hps_rd(25'd3, 8'hC3, "rd3");
      for (int i = 0; i < 3; i++) step();
      check("din_hold", ioctl_din, 8'hC3);
      for (int i = 0; i < 8; i++) begin
         a = 6'($urandom_range(0, 63));
         hps_rd(25'(a), model[a], "rd_rand");
      end
      hps_rd(25'($urandom_range(64, 33554431)), 8'hFF, "rd_far");
      ioctl_upload = 1'b0;
      step();
      check("upl_end_req", ioctl_upload_req, 1'b0);
      check("upl_end_dirty", dirty_o, 1'b0);
      check("upl_end_state", state_o, IDLE);

      // upload with a CPU write in the middle
      ioctl_upload = 1'b1;
      step();
      check("upl2_state", state_o, UPLOAD);
      cpu_op(1'b1, 6'd5, 8'h55);
      step();
      ioctl_upload = 1'b0;
      step();
      check("upl2_dirty", dirty_o, 1'b1);
      check("upl2_state_wait", state_o, WAIT);
      wait_req(n);
      check("upl2_redelay", n, SD);

      // download on the wrong index is ignored
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      for (int i = 0; i < 64; i++) begin
         ioctl_addr = 25'(i); ioctl_dout = ~8'(i); ioctl_wr = 1'b1;
         step();
      end
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      step();
      check("idx0_nv_valid", nv_valid, 1'b0);
      check("idx0_state", state_o, REQ);
      for (int i = 0; i < 3; i++) begin
         a = 6'($urandom_range(0, 63));
         cpu_op(1'b0, a, 8'h00);
         check("idx0_ram", cpu_dout, model[a]);
      end

      // restore download of 0..63 with an out-of-range byte and a CPU collision
      ioctl_index = 8'd4; ioctl_download = 1'b1;
      step();
      check("dl_state", state_o, DNLOAD);
      for (int i = 0; i < 65; i++) begin
         ioctl_addr = 25'(i); ioctl_dout = (i == 64) ? 8'hEE : 8'(i); ioctl_wr = 1'b1;
         if (i == 20) begin cpu_we = 1'b1; cpu_addr = 6'd20; cpu_din = 8'h99; end
         step();
         cpu_we = 1'b0;
         if (i < 64) model[i] = 8'(i);
      end
      ioctl_wr = 1'b0;
      step();
      check("dl_nv_before", nv_valid, 1'b0);
      ioctl_download = 1'b0;
      step();
      check("dl_nv_valid", nv_valid, 1'b1);
      check("dl_dirty", dirty_o, 1'b0);
      check("dl_state_idle", state_o, IDLE);
      cpu_op(1'b0, 6'd10, 8'h00); check("dl_rd10", cpu_dout, 8'h0A);
      cpu_op(1'b0, 6'd0, 8'h00);  check("dl_rd0", cpu_dout, 8'h00);
      cpu_op(1'b0, 6'd20, 8'h00); check("dl_collide", cpu_dout, 8'h14);
      cpu_op(1'b0, 6'd63, 8'h00); check("dl_rd63", cpu_dout, 8'h3F);

      // async reset in the middle of an upload
      cpu_op(1'b1, 6'd3, 8'hC3);
      ioctl_upload = 1'b1;
      step();
      hps_rd(25'd3, 8'hC3, "pre_rst_rd");
      ioctl_addr = 25'd5; ioctl_rd = 1'b1;
      step();
      reset = 1'b1;
      #1;
      check("mid_rst_din", ioctl_din, 8'h00);
      check("mid_rst_req", ioctl_upload_req, 1'b0);
      check("mid_rst_state", state_o, IDLE);
      check("mid_rst_nv", nv_valid, 1'b0);
      ioctl_rd = 1'b0; ioctl_upload = 1'b0;
      step();
      reset = 1'b0;
      step();
      cpu_op(1'b0, 6'd3, 8'h00);
      check("rst_keeps_ram", cpu_dout, 8'hC3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
